// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter that shares one UART transmitter among
// NUM_REQ byte-stream requesters and sequences the write/guard/ready protocol.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 uart_write_data,
  output logic                       uart_write_req,
  input  logic                       uart_ready,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [1:0] {ARB, ISSUE, GUARD, WAIT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  guard_cnt;
  logic [ID_W-1:0]   rr_ptr, rr_nxt;
  logic [ID_W-1:0]   lock_id;
  logic              locked, locked_nxt;
  logic              cand_found;
  logic [ID_W-1:0]   cand_id;
  logic [ID_W-1:0]   idx;
  logic              accept;
  logic [7:0]        acc_data;
  logic              acc_last;

  // Candidate: the locked requester only, else first valid scanning up from rr_ptr.
  always_comb begin
    cand_found = 1'b0;
    cand_id    = '0;
    idx        = '0;
    if (locked) begin
      cand_found = req_valid[lock_id];
      cand_id    = lock_id;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = ID_W'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
        if (!cand_found && req_valid[idx]) begin
          cand_found = 1'b1;
          cand_id    = idx;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ARB;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = GUARD;
      GUARD:   if (guard_cnt == '0) state_nxt = WAIT;
      WAIT:    if (uart_ready) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Output logic: accept handshake and the values it commits.
  always_comb begin
    accept     = 1'b0;
    req_ready  = '0;
    acc_data   = 8'h00;
    acc_last   = 1'b0;
    locked_nxt = locked;
    rr_nxt     = rr_ptr;
    if (reset_n && (state == ARB) && uart_ready && cand_found) begin
      accept    = 1'b1;
      req_ready = NUM_REQ'(1) << cand_id;
      acc_last  = req_last[cand_id];
      for (int k = 0; k < NUM_REQ; k++) begin
        if (cand_id == ID_W'(k)) acc_data = req_data[8*k +: 8];
      end
      locked_nxt = ~acc_last;
      if (acc_last) begin
        rr_nxt = (cand_id == ID_W'(NUM_REQ - 1)) ? '0 : cand_id + ID_W'(1);
      end
    end
  end

  // Registered datapath: write strobe/data, lock, pointer and guard timer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      uart_write_req  <= 1'b0;
      uart_write_data <= 8'h00;
      grant_id        <= '0;
      rr_ptr          <= '0;
      lock_id         <= '0;
      locked          <= 1'b0;
      busy            <= 1'b0;
      guard_cnt       <= '0;
    end else begin
      uart_write_req <= (state_nxt == ISSUE);
      busy           <= locked_nxt | (state_nxt != ARB);
      locked         <= locked_nxt;
      rr_ptr         <= rr_nxt;
      if (accept) begin
        uart_write_data <= acc_data;
        grant_id        <= cand_id;
        if (!acc_last) lock_id <= cand_id;
      end
      if (state == ISSUE) begin
        guard_cnt <= CNT_W'(GUARD_CYCLES - 1);
      end else if ((state == GUARD) && (guard_cnt != '0)) begin
        guard_cnt <= guard_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed messages, expected strobes
// queued at stimulus time and checked by an independent strobe monitor.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned G  = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic [7:0]    uart_write_data;
  logic          uart_write_req;
  logic          uart_ready;
  logic          busy;
  logic [0:0]    grant_id;

  uart_tx_arbiter #(.NUM_REQ(NR), .GUARD_CYCLES(G)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .uart_write_data(uart_write_data),
    .uart_write_req(uart_write_req), .uart_ready(uart_ready), .busy(busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] exp_q[$];          // {grant, data}
  logic [8:0] rq0[$], rq1[$];    // {last, data}
  int         strobe_cyc_q[$];
  int         strobe_cnt = 0;
  int         accept_cyc = -100;
  logic       tx_model    = 1'b0;
  logic       ready_force = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe monitor: one-hot accepts, 1-cycle latency, pulse width, scoreboard order.
  initial begin
    logic       prev_req;
    logic [8:0] e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        check("req_ready_onehot", $countones(req_ready), 1);
        accept_cyc = cyc;
      end
      if (uart_write_req === 1'b1) begin
        strobe_cnt++;
        strobe_cyc_q.push_back(cyc);
        check("strobe_latency", cyc - accept_cyc, 1);
        check("strobe_width", 32'(prev_req), 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got data 0x%0h, expected no strobe", uart_write_data);
        end else begin
          e = exp_q.pop_front();
          check("strobe_data", uart_write_data, 32'(e[7:0]));
          check("strobe_grant", grant_id, 32'(e[8]));
        end
      end
      prev_req = uart_write_req;
    end
  end

  // Requester drivers: present queue heads, retire on valid&ready.
  initial begin
    logic a0, a1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      a0 = req_valid[0] & req_ready[0];
      a1 = req_valid[1] & req_ready[1];
      @(posedge clk);
      #1;
      if (a0 && rq0.size() > 0) void'(rq0.pop_front());
      if (a1 && rq1.size() > 0) void'(rq1.pop_front());
      if (rq0.size() > 0) begin
        req_valid[0] = 1'b1; req_data[7:0] = rq0[0][7:0]; req_last[0] = rq0[0][8];
      end else req_valid[0] = 1'b0;
      if (rq1.size() > 0) begin
        req_valid[1] = 1'b1; req_data[15:8] = rq1[0][7:0]; req_last[1] = rq1[0][8];
      end else req_valid[1] = 1'b0;
    end
  end

  // Transmitter: busy for 10 cycles after each strobe when modelled, else forced.
  initial begin
    int tx_cnt;
    tx_cnt     = 0;
    uart_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_model) begin
        if (uart_write_req) tx_cnt = 10;
        else if (tx_cnt > 0) tx_cnt--;
        uart_ready = (tx_cnt == 0);
      end else begin
        tx_cnt     = 0;
        uart_ready = ready_force;
      end
    end
  end

  task automatic wait_strobes(input int n, input int budget);
    int t = 0;
    while (strobe_cnt < n && t < budget) begin
      @(negedge clk); #1; t++;
    end
    if (strobe_cnt < n) begin
      n_checks++; n_fail++;
      $display("FAIL strobe_timeout: got %0d strobes, expected %0d", strobe_cnt, n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    @(negedge clk); #1;
    while (!(busy == 1'b0 && exp_q.size() == 0) && t < budget) begin
      @(negedge clk); #1; t++;
    end
    check("idle_busy", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset_n = 1'b0;
    rq0.delete(); rq1.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int bad, n;
    reset_n = 1'b0;
    rq0.push_back({1'b1, 8'h41});
    exp_q.push_back({1'b0, 8'h41});
    repeat (3) @(negedge clk);
    #1;
    check("rst_write_req", uart_write_req, 0);
    check("rst_write_data", uart_write_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);

    // Single byte from req0.
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk); #1;
    check("single_req_ready", req_ready, 2'b01);
    @(negedge clk); #1;
    check("single_ready_drop", req_ready, 2'b00);
    wait_strobes(1, 50);
    wait_idle(50);

    // Pointer advanced to 1: req1 wins a simultaneous request.
    rq0.push_back({1'b1, 8'h01});
    rq1.push_back({1'b1, 8'h02});
    exp_q.push_back({1'b1, 8'h02});
    exp_q.push_back({1'b0, 8'h01});
    wait_strobes(3, 100);
    wait_idle(50);

    // Round-robin with a modelled transmitter.
    do_reset();
    tx_model = 1'b1;
    rq0.push_back({1'b1, 8'hA0}); rq0.push_back({1'b1, 8'hA0});
    rq1.push_back({1'b1, 8'hB0}); rq1.push_back({1'b1, 8'hB0});
    exp_q.push_back({1'b0, 8'hA0}); exp_q.push_back({1'b1, 8'hB0});
    exp_q.push_back({1'b0, 8'hA0}); exp_q.push_back({1'b1, 8'hB0});
    wait_strobes(7, 200);
    wait_idle(50);

    // Lock: req0 3-byte message is never interleaved with req1.
    rq0.push_back({1'b0, 8'h11}); rq0.push_back({1'b0, 8'h22}); rq0.push_back({1'b1, 8'h33});
    rq1.push_back({1'b1, 8'h99});
    exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b0, 8'h33}); exp_q.push_back({1'b1, 8'h99});
    wait_strobes(11, 200);
    wait_idle(50);

    // Stall: uart_ready low for 50 cycles.
    tx_model    = 1'b0;
    ready_force = 1'b0;
    rq0.push_back({1'b1, 8'h77});
    exp_q.push_back({1'b0, 8'h77});
    bad = 0;
    repeat (50) begin
      @(negedge clk); #1;
      if (req_ready !== 2'b00 || uart_write_req !== 1'b0) bad++;
    end
    check("stall_quiet_cycles", bad, 0);
    ready_force = 1'b1;
    @(negedge clk); #1;
    check("stall_accept_on_rise", req_ready, 2'b01);
    wait_strobes(12, 20);
    wait_idle(50);

    // Guard spacing with uart_ready stuck high.
    strobe_cyc_q.delete();
    rq0.push_back({1'b1, 8'h61}); rq0.push_back({1'b1, 8'h62}); rq0.push_back({1'b1, 8'h63});
    exp_q.push_back({1'b0, 8'h61}); exp_q.push_back({1'b0, 8'h62}); exp_q.push_back({1'b0, 8'h63});
    wait_strobes(15, 100);
    if (strobe_cyc_q.size() >= 3) begin
      check("guard_gap_1", strobe_cyc_q[1] - strobe_cyc_q[0], G + 3);
      check("guard_gap_2", strobe_cyc_q[2] - strobe_cyc_q[1], G + 3);
    end else begin
      n_checks++; n_fail++;
      $display("FAIL guard_strobes: got %0d strobes, expected 3", strobe_cyc_q.size());
    end
    wait_idle(50);

    // Reset in the ISSUE cycle of byte 2 of a locked req1 message.
    rq1.push_back({1'b0, 8'h51}); rq1.push_back({1'b0, 8'h52}); rq1.push_back({1'b1, 8'h53});
    exp_q.push_back({1'b1, 8'h51}); exp_q.push_back({1'b1, 8'h52});
    n = strobe_cnt + 2;
    wait_strobes(n, 100);
    check("midrst_busy_before", busy, 1);
    reset_n = 1'b0;
    rq1.delete();
    rq0.push_back({1'b1, 8'hC0});
    rq1.push_back({1'b1, 8'hC1});
    exp_q.push_back({1'b0, 8'hC0});
    exp_q.push_back({1'b1, 8'hC1});
    @(negedge clk); #1;
    check("midrst_write_req", uart_write_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_grant_id", grant_id, 0);
    check("midrst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_strobes(n + 2, 100);
    wait_idle(50);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
